// File: rtl/sw_pkg.sv
// Shared types and helpers for the switch debounce / event front end.
package sw_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } evt_state_t;

    // Counter width for a debounce window; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: synchroniser chain, debounce counter, stable bit and
// registered rise/fall pulses.
module debounce_ch
    import sw_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic change,
    output logic stable_next
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [CW-1:0]          cnt;

    assign synced = sync[SYNC_STAGES-1];

    // change is combinational so the event logic sees it on the same edge
    // that STABLE takes its new value.
    assign change      = (synced != stable) && (cnt == LIMIT);
    assign stable_next = change ? synced : stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], sw};
            stable <= stable_next;
            rise   <= change & synced;
            fall   <= change & ~synced;
            if ((synced == stable) || change) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce_evt.sv
// Slide-switch bank front end: per-channel debounce plus a single-entry
// change snapshot held under a valid/ack handshake with sticky overflow.
module sw_debounce_evt
    import sw_pkg::*;
#(
    parameter int N               = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] SW,
    output logic [N-1:0] STABLE,
    output logic [N-1:0] RISE,
    output logic [N-1:0] FALL,
    output logic         EVT_VALID,
    output logic [N-1:0] EVT_DATA,
    output logic         EVT_OVF,
    input  logic         EVT_ACK
);

    logic [N-1:0] ch_change;
    logic [N-1:0] stable_next;
    logic         change;

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (CLK),
            .rst        (RST),
            .sw         (SW[i]),
            .stable     (STABLE[i]),
            .rise       (RISE[i]),
            .fall       (FALL[i]),
            .change     (ch_change[i]),
            .stable_next(stable_next[i])
        );
    end

    assign change = |ch_change;

    // Handshake: EVT_VALID stays high until a cycle with EVT_ACK=1 and no
    // new change; EVT_DATA only moves on a change edge; ack in IDLE is ignored.
    evt_state_t   state, state_n;
    logic [N-1:0] data_n;
    logic         ovf_n;

    assign EVT_VALID = (state == PEND);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            EVT_DATA <= '0;
            EVT_OVF  <= 1'b0;
        end else begin
            state    <= state_n;
            EVT_DATA <= data_n;
            EVT_OVF  <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = EVT_DATA;
        ovf_n   = EVT_OVF;
        case (state)
            IDLE: begin
                if (change) begin
                    data_n  = stable_next;
                    ovf_n   = 1'b0;
                    state_n = PEND;
                end
            end
            PEND: begin
                if (EVT_ACK && change) begin
                    data_n = stable_next;
                    ovf_n  = 1'b0;
                end else if (EVT_ACK) begin
                    ovf_n   = 1'b0;
                    state_n = IDLE;
                end else if (change) begin
                    data_n = stable_next;
                    ovf_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sw_debounce_evt.sv
// Bench for sw_debounce_evt: directed scenarios plus random switch bounce,
// checked every cycle against a window-based reference model.
module tb_sw_debounce_evt;

    localparam int N  = 12;
    localparam int SS = 2;
    localparam int DB = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] SW;
    logic [N-1:0] STABLE, RISE, FALL, EVT_DATA;
    logic         EVT_VALID, EVT_OVF, EVT_ACK;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state
    logic [N-1:0] sync_q[$];
    logic [N-1:0] win_q[$];
    logic [N-1:0] m_stable, m_rise, m_fall, m_data;
    logic         m_valid, m_ovf;

    sw_debounce_evt #(
        .N              (N),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SW       (SW),
        .STABLE   (STABLE),
        .RISE     (RISE),
        .FALL     (FALL),
        .EVT_VALID(EVT_VALID),
        .EVT_DATA (EVT_DATA),
        .EVT_OVF  (EVT_OVF),
        .EVT_ACK  (EVT_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sync_q.delete();
        win_q.delete();
        for (int i = 0; i < SS; i++) sync_q.push_back('0);
        for (int i = 0; i < DB; i++) win_q.push_back('0);
        m_stable = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_data   = '0;
        m_valid  = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // A bit flips once its synced value has disagreed with the stable value
    // for the last DB clock edges in a row.
    task automatic model_edge(input logic [N-1:0] sw_v, input logic ack_v);
        logic [N-1:0] synced, nxt;
        int           cnt;
        synced = sync_q[SS-1];
        sync_q.push_front(sw_v);
        void'(sync_q.pop_back());
        win_q.push_back(synced);
        void'(win_q.pop_front());
        nxt = m_stable;
        for (int c = 0; c < N; c++) begin
            cnt = 0;
            foreach (win_q[k]) if (win_q[k][c] != m_stable[c]) cnt++;
            if (cnt == DB) nxt[c] = ~m_stable[c];
        end
        m_rise = nxt & ~m_stable;
        m_fall = ~nxt & m_stable;
        if (nxt != m_stable) begin
            m_data  = nxt;
            m_ovf   = m_valid & ~ack_v;
            m_valid = 1'b1;
        end else if (ack_v) begin
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end
        m_stable = nxt;
    endtask

    task automatic compare_all();
        check("stable", STABLE, m_stable);
        check("rise", RISE, m_rise);
        check("fall", FALL, m_fall);
        check("evt_valid", N'(EVT_VALID), N'(m_valid));
        check("evt_data", EVT_DATA, m_data);
        check("evt_ovf", N'(EVT_OVF), N'(m_ovf));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [N-1:0] sw_v, input logic ack_v);
        SW      = sw_v;
        EVT_ACK = ack_v;
        @(posedge CLK);
        model_edge(sw_v, ack_v);
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    task automatic do_reset(input logic [N-1:0] sw_v);
        SW      = sw_v;
        EVT_ACK = 1'b0;
        RST     = 1'b1;
        #1;
        model_reset();
        check("rst_stable", STABLE, '0);
        check("rst_rise_fall", RISE | FALL, '0);
        check("rst_evt", {EVT_DATA[N-3:0], EVT_VALID, EVT_OVF}, '0);
        @(posedge CLK);
        #1;
        compare_all();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_latency(input string tag, input logic [N-1:0] sw_v, input int exp_edges);
        int  edges;
        bit  seen;
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(sw_v, 1'b0);
            edges++;
            if (STABLE === sw_v) seen = 1'b1;
        end
        check(tag, N'(edges), N'(exp_edges));
    endtask

    initial begin
        logic [N-1:0] sw_r, one, val;
        logic [3:0]   nib;
        RST     = 1'b1;
        SW      = '0;
        EVT_ACK = 1'b0;
        model_reset();
        @(negedge CLK);

        // 1: reset with all switches high, then release
        do_reset('1);
        wait_latency("t1_latency", '1, SS + DB);
        check("t1_rise", RISE, '1);
        check("t1_valid", N'(EVT_VALID), N'(1));
        check("t1_data", EVT_DATA, '1);

        // 2: clean step 000 -> 111, then a short glitch on bit 0
        for (int i = 0; i < 10; i++) step(12'h000, 1'b1);
        wait_latency("t2_latency", 12'h111, SS + DB);
        check("t2_rise", RISE, 12'h111);
        check("t2_fall", FALL, 12'h000);
        step(12'h111, 1'b1);
        for (int i = 0; i < 11; i++) begin
            step((i < 3) ? 12'h110 : 12'h111, 1'b0);
            check("t2_glitch_stable", STABLE, 12'h111);
            check("t2_glitch_pulse", RISE | FALL, '0);
            check("t2_glitch_evt", N'(EVT_VALID), N'(0));
        end

        // 3: two changes without ack -> overflow
        for (int i = 0; i < 8; i++) step(12'h222, 1'b0);
        for (int i = 0; i < 8; i++) step(12'h333, 1'b0);
        check("t3_data", EVT_DATA, 12'h333);
        check("t3_ovf", N'(EVT_OVF), N'(1));
        check("t3_valid", N'(EVT_VALID), N'(1));

        // 4: ack on the same edge STABLE goes 333 -> 444, then a plain ack
        for (int i = 1; i <= SS + DB; i++) step(12'h444, (i == SS + DB));
        check("t4_valid", N'(EVT_VALID), N'(1));
        check("t4_data", EVT_DATA, 12'h444);
        check("t4_ovf", N'(EVT_OVF), N'(0));
        check("t4_stable", STABLE, 12'h444);
        step(12'h444, 1'b1);
        check("t4_ack_valid", N'(EVT_VALID), N'(0));
        check("t4_ack_ovf", N'(EVT_OVF), N'(0));

        // 5: reset two cycles after a step
        step(12'h555, 1'b0);
        step(12'h555, 1'b0);
        do_reset(12'h555);
        wait_latency("t5_latency", 12'h555, SS + DB);
        step(12'h555, 1'b1);

        // 6: sweep 000..fff, acking each event
        for (int v = 0; v < 16; v++) begin
            nib = v[3:0];
            val = {3{nib}};
            for (int k = 0; k < 10; k++) step(val, m_valid);
            check("t6_data", EVT_DATA, val);
            check("t6_ovf", N'(EVT_OVF), N'(0));
        end

        // 7: random bounce and random acks
        sw_r = STABLE;
        one  = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)
                sw_r = N'($urandom);
            else if ($urandom_range(0, 2) == 0)
                sw_r = sw_r ^ (one << $urandom_range(0, N - 1));
            step(sw_r, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
